// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Round-robin arbiter placing NUM_PORTS requesters onto one sdram_controller
// user port. One port holds the grant for up to BURST_MAX accepted accesses.
// The grant is also released when the granted port drops Req. A CAS_LATENCY
// deep pipe records which port issued each read. That pipe routes the returned
// word back to its port. The same pipe holds off writes until DQ is free.
// Optional feature macro: SDRAM_ARB_FOCUS_EN (drives Ctl_Focus inside bursts).
module sdram_port_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int CAS_LATENCY = 2,
    parameter int BURST_MAX   = 4
) (
    input  logic                        Clk,
    input  logic                        Reset_N,
    input  logic [NUM_PORTS-1:0]        Req,
    input  logic [NUM_PORTS-1:0]        Req_WE,
    input  logic [NUM_PORTS*ADDR_W-1:0] Req_Addr,
    input  logic [NUM_PORTS*DATA_W-1:0] Req_Din,
    output logic [NUM_PORTS-1:0]        Ack,
    output logic [NUM_PORTS-1:0]        Rd_Valid,
    output logic [DATA_W-1:0]           Rd_Data,
    output logic                        Ctl_WE,
    output logic                        Ctl_Focus,
    output logic [ADDR_W-1:0]           Ctl_Addr,
    output logic [DATA_W-1:0]           Ctl_Din,
    input  logic [DATA_W-1:0]           Ctl_Dout,
    input  logic                        Ctl_R
);

    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BC_W = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                               state, state_nxt;
    logic [ID_W-1:0]                      gnt, rr_ptr, pick, gnt_inc;
    logic                                 found;
    int                                   sel_idx;
    logic [ADDR_W-1:0]                    last_addr;
    logic [BC_W-1:0]                      burst_cnt;
    logic                                 accept, rel_grant, rd_busy;

    // Read pipe: stage i holds a read accepted i cycles ago.
    logic [CAS_LATENCY:1]                 vld_pipe;
    logic [CAS_LATENCY:1][ID_W-1:0]       id_pipe;

    // Per-port views of the packed request buses.
    logic [NUM_PORTS-1:0][ADDR_W-1:0]     req_addr_a;
    logic [NUM_PORTS-1:0][DATA_W-1:0]     req_din_a;

    assign req_addr_a = Req_Addr;
    assign req_din_a  = Req_Din;
    assign rd_busy    = |vld_pipe;
    assign gnt_inc    = (gnt == ID_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    // Walk downward so the closest candidate is the last one written.
    always_comb begin
        found   = 1'b0;
        pick    = rr_ptr;
        sel_idx = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            sel_idx = int'(rr_ptr) + i;
            if (sel_idx >= NUM_PORTS) sel_idx = sel_idx - NUM_PORTS;
            if (Req[sel_idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = sel_idx[ID_W-1:0];
            end
        end
    end

    // Next state and controller-side outputs. Idle cycles replay last_addr
    // so the controller never sees a spurious row change.
    always_comb begin
        state_nxt = state;
        Ack       = '0;
        Ctl_WE    = 1'b0;
        Ctl_Addr  = last_addr;
        Ctl_Din   = '0;
        accept    = 1'b0;
        rel_grant = 1'b0;
        case (state)
            IDLE: begin
                if (found) state_nxt = BUSY;
            end
            BUSY: begin
                Ctl_Addr  = req_addr_a[gnt];
                Ctl_Din   = req_din_a[gnt];
                // A write must wait for DQ to turn around after reads.
                accept    = Req[gnt] & Ctl_R & ~(Req_WE[gnt] & rd_busy);
                Ack[gnt]  = accept;
                Ctl_WE    = Req[gnt] & Req_WE[gnt] & ~rd_busy;
                rel_grant = ~Req[gnt] |
                            (accept & (burst_cnt == BC_W'(BURST_MAX - 1)));
                if (rel_grant) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SDRAM_ARB_FOCUS_EN
    // Hold the row open (defer refresh) while more accepts of this burst follow.
    assign Ctl_Focus = (state == BUSY) & Req[gnt] &
                       (burst_cnt < BC_W'(BURST_MAX - 1));
`else
    assign Ctl_Focus = 1'b0;
`endif

    // Grant bookkeeping: state, granted port, round-robin pointer, burst count.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            last_addr <= '0;
            burst_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (found) begin
                    gnt       <= pick;
                    burst_cnt <= '0;
                end
            end else begin
                if (accept) begin
                    last_addr <= Ctl_Addr;
                    burst_cnt <= burst_cnt + 1'b1;
                end
                if (rel_grant) rr_ptr <= gnt_inc;
            end
        end
    end

    // Read pipe shift: a read accept enters stage 1; stages age by one per cycle.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[1] <= accept & ~Req_WE[gnt];
            id_pipe[1]  <= gnt;
            for (int i = 2; i <= CAS_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    // Capture the returning word as its read reaches the last stage.
    // Raise that port's Rd_Valid together with the captured word.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            Rd_Data  <= '0;
            Rd_Valid <= '0;
        end else begin
            Rd_Valid <= '0;
            if (vld_pipe[CAS_LATENCY]) begin
                Rd_Data                       <= Ctl_Dout;
                Rd_Valid[id_pipe[CAS_LATENCY]] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter. Directed tables and sequences, then
// random traffic scored against a cycle-count reference model.
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int CL = 2;
    localparam int BM = 4;

    logic                   Clk = 1'b0;
    logic                   Reset_N = 1'b0;
    logic [NP-1:0]          req = '0;
    logic [NP-1:0]          we = '0;
    logic [NP-1:0][AW-1:0]  addr = '0;
    logic [NP-1:0][DW-1:0]  din = '0;
    logic [NP-1:0]          Ack, Rd_Valid;
    logic [DW-1:0]          Rd_Data, Ctl_Din;
    logic                   Ctl_WE, Ctl_Focus;
    logic [AW-1:0]          Ctl_Addr;
    logic [DW-1:0]          Ctl_Dout = '0;
    logic                   Ctl_R = 1'b1;

    int n_chk = 0;
    int n_pass = 0;

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
                         .CAS_LATENCY(CL), .BURST_MAX(BM)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .Req(req), .Req_WE(we),
        .Req_Addr(addr), .Req_Din(din), .Ack(Ack), .Rd_Valid(Rd_Valid),
        .Rd_Data(Rd_Data), .Ctl_WE(Ctl_WE), .Ctl_Focus(Ctl_Focus),
        .Ctl_Addr(Ctl_Addr), .Ctl_Din(Ctl_Din), .Ctl_Dout(Ctl_Dout),
        .Ctl_R(Ctl_R));

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 64'(Ack), 64'd0);
        chk({tag, "_rv"}, 64'(Rd_Valid), 64'd0);
        chk({tag, "_rdata"}, 64'(Rd_Data), 64'd0);
        chk({tag, "_we"}, 64'(Ctl_WE), 64'd0);
        chk({tag, "_focus"}, 64'(Ctl_Focus), 64'd0);
        chk({tag, "_addr"}, 64'(Ctl_Addr), 64'd0);
        chk({tag, "_din"}, 64'(Ctl_Din), 64'd0);
    endtask

    task automatic do_reset();
        Reset_N = 1'b0;
        req = '0; we = '0; Ctl_R = 1'b1; Ctl_Dout = '0;
        repeat (2) @(negedge Clk);
        chk_all_zero("reset");
        Reset_N = 1'b1;
    endtask

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] we;
        logic          r;
        logic [DW-1:0] dout;
        logic [NP-1:0] ack;
        logic          cwe;
        logic [NP-1:0] rv;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tv[12];

    typedef struct { int cyc; int port; } rd_t;
    rd_t rdq[$];

    // Reference model state
    int              m_busy, m_gnt, m_cnt, m_rr, m_last_rd, cyc;
    logic [AW-1:0]   m_last_addr;
    logic [DW-1:0]   m_rd_data, prev_dout;

    initial begin
        logic [NP-1:0] e_ack, last_ack, e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic          e_we, e_focus, acc, rbusy;
        int            g, k;

        // Port1 read with its return, then a port0 read followed by a write.
        tv[0]  = '{4'b0010, 4'b0000, 1'b1, 16'h0000, 4'b0000, 1'b0, 4'b0000, 16'h0000};
        tv[1]  = '{4'b0010, 4'b0000, 1'b1, 16'h0000, 4'b0010, 1'b0, 4'b0000, 16'h0000};
        tv[2]  = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 1'b0, 4'b0000, 16'h0000};
        tv[3]  = '{4'b0000, 4'b0000, 1'b1, 16'hBEEF, 4'b0000, 1'b0, 4'b0000, 16'h0000};
        tv[4]  = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 1'b0, 4'b0010, 16'hBEEF};
        tv[5]  = '{4'b0001, 4'b0000, 1'b1, 16'h0000, 4'b0000, 1'b0, 4'b0000, 16'hBEEF};
        tv[6]  = '{4'b0001, 4'b0000, 1'b1, 16'h0000, 4'b0001, 1'b0, 4'b0000, 16'hBEEF};
        tv[7]  = '{4'b0001, 4'b0001, 1'b1, 16'h0000, 4'b0000, 1'b0, 4'b0000, 16'hBEEF};
        tv[8]  = '{4'b0001, 4'b0001, 1'b1, 16'h1234, 4'b0000, 1'b0, 4'b0000, 16'hBEEF};
        tv[9]  = '{4'b0001, 4'b0001, 1'b1, 16'h0000, 4'b0001, 1'b1, 4'b0001, 16'h1234};
        tv[10] = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 1'b0, 4'b0000, 16'h1234};
        tv[11] = '{4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 1'b0, 4'b0000, 16'h1234};

        do_reset();
        addr[1] = 25'h0000123;
        addr[0] = 25'h0000040;
        din[0]  = 16'h5A5A;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk); #1;
            req = tv[i].req; we = tv[i].we; Ctl_R = tv[i].r; Ctl_Dout = tv[i].dout;
            @(negedge Clk);
            chk($sformatf("tv%0d_ack", i), 64'(Ack), 64'(tv[i].ack));
            chk($sformatf("tv%0d_ctlwe", i), 64'(Ctl_WE), 64'(tv[i].cwe));
            chk($sformatf("tv%0d_rv", i), 64'(Rd_Valid), 64'(tv[i].rv));
            chk($sformatf("tv%0d_rdata", i), 64'(Rd_Data), 64'(tv[i].rdata));
            if (i == 9) chk("tv9_din", 64'(Ctl_Din), 64'h5A5A);
        end

        // All ports requesting: grant order 0,1,2,3,0; 4 Acks then a bubble.
        do_reset();
        for (int k2 = 0; k2 < 25; k2++) begin
            @(posedge Clk); #1;
            req = 4'b1111; we = 4'b0000; Ctl_R = 1'b1;
            @(negedge Clk);
            if (k2 % 5 == 0) begin
                chk($sformatf("rr%0d_ack", k2), 64'(Ack), 64'd0);
                chk($sformatf("rr%0d_focus", k2), 64'(Ctl_Focus), 64'd0);
            end else begin
                chk($sformatf("rr%0d_ack", k2), 64'(Ack), 64'(1 << ((k2 / 5) % NP)));
`ifdef SDRAM_ARB_FOCUS_EN
                chk($sformatf("rr%0d_focus", k2), 64'(Ctl_Focus), 64'((k2 % 5) < BM));
`else
                chk($sformatf("rr%0d_focus", k2), 64'(Ctl_Focus), 64'd0);
`endif
            end
        end

        // Reset mid-burst with reads in flight: outputs clear at once, no late Rd_Valid.
        do_reset();
        addr[0] = 25'h1ABCDEF; din[0] = 16'h7777;
        Ctl_Dout = 16'hCAFE;
        for (int k2 = 0; k2 < 3; k2++) begin
            @(posedge Clk); #1;
            req = 4'b0001; we = 4'b0000; Ctl_R = 1'b1;
        end
        @(negedge Clk);
        chk("mid_ack", 64'(Ack), 64'd1);
        @(posedge Clk); #2;
        Reset_N = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge Clk);
        req = '0;
        Reset_N = 1'b1;
        for (int k2 = 0; k2 < 6; k2++) begin
            @(negedge Clk);
            chk($sformatf("post_rst%0d_rv", k2), 64'(Rd_Valid), 64'd0);
        end

        // Ctl_R low for 6 cycles: grant and address held, burst resumes afterwards.
        do_reset();
        addr[2] = 25'h0A5A5A5;
        for (int k2 = 0; k2 < 12; k2++) begin
            @(posedge Clk); #1;
            req = 4'b0100; we = 4'b0000;
            Ctl_R = (k2 >= 2 && k2 <= 7) ? 1'b0 : 1'b1;
            @(negedge Clk);
            if (k2 == 0 || k2 == 11)
                chk($sformatf("rlow%0d_ack", k2), 64'(Ack), 64'd0);
            else if (k2 >= 2 && k2 <= 7) begin
                chk($sformatf("rlow%0d_ack", k2), 64'(Ack), 64'd0);
                chk($sformatf("rlow%0d_addr", k2), 64'(Ctl_Addr), 64'h0A5A5A5);
            end else
                chk($sformatf("rlow%0d_ack", k2), 64'(Ack), 64'b0100);
        end

        // Random traffic against the reference model.
        do_reset();
        m_busy = 0; m_gnt = 0; m_cnt = 0; m_rr = 0; m_last_rd = -100; cyc = 0;
        m_last_addr = '0; m_rd_data = '0; prev_dout = '0; rdq.delete();
        last_ack = '0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge Clk); #1;
            req = req & ~last_ack;
            for (int p = 0; p < NP; p++) begin
                if (!req[p] && $urandom_range(0, 2) == 0) begin
                    req[p]  = 1'b1;
                    we[p]   = 1'($urandom_range(0, 1));
                    addr[p] = AW'($urandom);
                    din[p]  = DW'($urandom);
                end
            end
            Ctl_R    = ($urandom_range(0, 4) != 0);
            Ctl_Dout = DW'($urandom);
            @(negedge Clk);

            // Model: reads are in flight for CL cycles after their accept.
            rbusy = (cyc - m_last_rd) <= CL;
            e_rv = '0;
            if (rdq.size() > 0 && rdq[0].cyc + CL + 1 == cyc) begin
                e_rv[rdq[0].port] = 1'b1;
                m_rd_data = prev_dout;
                void'(rdq.pop_front());
            end
            e_ack = '0; e_we = 1'b0; e_focus = 1'b0; e_addr = m_last_addr; e_din = '0;
            if (m_busy == 0) begin
                for (k = 0; k < NP; k++) begin
                    g = (m_rr + k) % NP;
                    if (req[g]) break;
                end
                if (k < NP) begin
                    m_busy = 1; m_gnt = g; m_cnt = 0;
                end
            end else begin
                g      = m_gnt;
                e_addr = addr[g];
                e_din  = din[g];
                acc    = req[g] && Ctl_R && !(we[g] && rbusy);
                e_we   = req[g] && we[g] && !rbusy;
`ifdef SDRAM_ARB_FOCUS_EN
                e_focus = req[g] && (m_cnt < BM - 1);
`endif
                if (acc) begin
                    e_ack[g] = 1'b1;
                    m_last_addr = addr[g];
                    m_cnt++;
                    if (!we[g]) begin
                        m_last_rd = cyc;
                        rdq.push_back('{cyc, g});
                    end
                end
                if (!req[g] || (acc && m_cnt == BM)) begin
                    m_busy = 0;
                    m_rr = (g + 1) % NP;
                end
            end
            chk("rnd_ack", 64'(Ack), 64'(e_ack));
            chk("rnd_ctlwe", 64'(Ctl_WE), 64'(e_we));
            chk("rnd_addr", 64'(Ctl_Addr), 64'(e_addr));
            chk("rnd_din", 64'(Ctl_Din), 64'(e_din));
            chk("rnd_focus", 64'(Ctl_Focus), 64'(e_focus));
            chk("rnd_rv", 64'(Rd_Valid), 64'(e_rv));
            chk("rnd_rdata", 64'(Rd_Data), 64'(m_rd_data));
            last_ack  = e_ack;
            prev_dout = Ctl_Dout;
            cyc++;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
